// File: rtl/asrm_cpu.sv
// ---------------------------------------------------------------------------
// asrm_cpu - minimal accumulator CPU with a single shared memory port.
//
// Instructions are 8 bits: opcode = instr[7:4], operand register n = instr[3:0].
// There are 16 registers of WORDSIZE bits:
//   R0 = WR (accumulator), R1 = SR (bit0 = compare flag), R2 = SP, R3 = PC.
// The memory port is shared between instruction fetch and data access. The
// memory is expected to have synchronous read: data_in carries the word
// addressed by addr one cycle after addr was presented.
//
// Optional feature macro: ASRM_STACK_EN
//   defined   : push / pop / call / ret use an upward-growing stack at SP
//               (SP points to the next free slot).
//   undefined : opcodes 0x09-0x0C are no-ops and SP is a plain register.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high; clears all state
//   quit      out  high once a quit instruction has executed, until reset
//   data_in   in   memory read data (WORDSIZE)
//   addr      out  memory address (WORDSIZE)
//   data_out  out  memory write data (WORDSIZE)
//   write_en  out  memory write strobe, one cycle per store
//
// FSM states:
//   state    | meaning
//   ---------+---------------------------------------------------------
//   FETCH    | addr holds PC; memory is returning the instruction
//   EXEC     | decode data_in[7:0] and execute; set up any memory access
//   MEM_RD   | data address presented; memory is returning the word
//   MEM_WB   | store: write_en high; load/pop/ret: capture data_in
//   HALT     | quit executed; bus idle until reset
// ---------------------------------------------------------------------------
module asrm_cpu #(
  parameter int WORDSIZE = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic                quit,
  input  logic [WORDSIZE-1:0] data_in,
  output logic [WORDSIZE-1:0] addr,
  output logic [WORDSIZE-1:0] data_out,
  output logic                write_en
);

  localparam int R_WR = 0;
  localparam int R_SR = 1;
  localparam int R_SP = 2;
  localparam int R_PC = 3;

  localparam logic [WORDSIZE-1:0] ONE = WORDSIZE'(1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM_RD,
    S_MEM_WB,
    S_HALT
  } state_t;

  // What MEM_WB does with the returned word (nothing for a store cycle).
  typedef enum logic [1:0] {
    WB_NONE,
    WB_WR,
    WB_PC
  } wb_t;

  state_t              state_q, state_d;
  wb_t                 wb_q, wb_d;
  logic [WORDSIZE-1:0] regs_q [16];
  logic [WORDSIZE-1:0] regs_d [16];
  logic [WORDSIZE-1:0] addr_q, addr_d;
  logic [WORDSIZE-1:0] dout_q, dout_d;
  logic                we_q, we_d;
  logic                quit_q, quit_d;

  logic [7:0]          instr;
  logic [3:0]          opcode;
  logic [3:0]          n;
  logic [WORDSIZE-1:0] wr;
  logic [WORDSIZE-1:0] rn;
  logic [WORDSIZE-1:0] pc_inc;

  assign instr  = data_in[7:0];
  assign opcode = instr[7:4];
  assign n      = instr[3:0];
  assign wr     = regs_q[R_WR];
  assign rn     = regs_q[n];
  assign pc_inc = regs_q[R_PC] + ONE;

  always_comb begin
    state_d = state_q;
    wb_d    = wb_q;
    regs_d  = regs_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    we_d    = 1'b0;
    quit_d  = quit_q;

    case (state_q)
      S_FETCH: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d       = S_FETCH;
        regs_d[R_PC]  = pc_inc;
        case (opcode)
          4'h1: regs_d[R_WR] = {{(WORDSIZE-4){1'b0}}, n};
          4'h2: regs_d[R_WR] = rn;
          // Written after the PC increment so that cpy R3 acts as a jump.
          4'h3: regs_d[n] = wr;
          4'h4: regs_d[R_WR] = wr + rn;
          4'h5: regs_d[R_WR] = wr - rn;
          4'h6: regs_d[R_WR] = wr & rn;
          4'h7: regs_d[R_WR] = wr | rn;
          4'h8: regs_d[R_WR] = wr ^ rn;
          4'h9: regs_d[R_WR] = ~rn;
          4'hA: regs_d[R_WR] = wr << rn;
          4'hB: regs_d[R_WR] = wr >> rn;
          4'hC: regs_d[R_SR][0] = (wr == rn);
          4'hD: regs_d[R_SR][0] = (wr < rn);
          4'hE: begin
            addr_d  = rn;
            dout_d  = wr;
            we_d    = 1'b1;
            wb_d    = WB_NONE;
            state_d = S_MEM_WB;
          end
          4'hF: begin
            addr_d  = rn;
            wb_d    = WB_WR;
            state_d = S_MEM_RD;
          end
          default: begin
            case (n)
              4'h8: begin
                if (regs_q[R_SR][0]) begin
                  regs_d[R_PC] = wr;
                end
              end
              4'hD: regs_d[R_SR][0] = ~regs_q[R_SR][0];
              4'hF: begin
                quit_d  = 1'b1;
                state_d = S_HALT;
              end
`ifdef ASRM_STACK_EN
              4'h9: begin
                regs_d[R_SP] = regs_q[R_SP] - ONE;
                addr_d       = regs_q[R_SP] - ONE;
                wb_d         = WB_WR;
                state_d      = S_MEM_RD;
              end
              4'hA: begin
                addr_d       = regs_q[R_SP];
                dout_d       = wr;
                we_d         = 1'b1;
                regs_d[R_SP] = regs_q[R_SP] + ONE;
                wb_d         = WB_NONE;
                state_d      = S_MEM_WB;
              end
              4'hB: begin
                addr_d       = regs_q[R_SP];
                dout_d       = pc_inc;
                we_d         = 1'b1;
                regs_d[R_SP] = regs_q[R_SP] + ONE;
                regs_d[R_PC] = wr;
                wb_d         = WB_NONE;
                state_d      = S_MEM_WB;
              end
              4'hC: begin
                regs_d[R_SP] = regs_q[R_SP] - ONE;
                addr_d       = regs_q[R_SP] - ONE;
                wb_d         = WB_PC;
                state_d      = S_MEM_RD;
              end
`endif
              default: ;
            endcase
          end
        endcase
        // The next fetch address is registered here so that addr already
        // equals PC during the FETCH cycle.
        if (state_d == S_FETCH) begin
          addr_d = regs_d[R_PC];
        end
      end

      S_MEM_RD: begin
        state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        state_d = S_FETCH;
        addr_d  = regs_q[R_PC];
        case (wb_q)
          WB_WR: regs_d[R_WR] = data_in;
          WB_PC: begin
            regs_d[R_PC] = data_in;
            addr_d       = data_in;
          end
          default: ;
        endcase
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wb_q    <= WB_NONE;
      addr_q  <= '0;
      dout_q  <= '0;
      we_q    <= 1'b0;
      quit_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      quit_q  <= quit_d;
      regs_q  <= regs_d;
    end
  end

  assign addr     = addr_q;
  assign data_out = dout_q;
  assign write_en = we_q;
  assign quit     = quit_q;

endmodule

// File: tb/tb_asrm_cpu.sv
module tb_asrm_cpu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         quit;
  logic [W-1:0] data_in;
  logic [W-1:0] addr;
  logic [W-1:0] data_out;
  logic         write_en;

  asrm_cpu #(.WORDSIZE(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .quit     (quit),
    .data_in  (data_in),
    .addr     (addr),
    .data_out (data_out),
    .write_en (write_en)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory with a load port used while the CPU is in reset.
  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00;
  logic [7:0] ld_data = 8'h00;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (write_en) mem[addr] <= data_out;
    data_in <= mem[addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: instruction-level interpreter that emits the bus
  // behaviour expected for each clock cycle of each instruction.
  typedef struct {
    bit         chk_addr;
    logic [7:0] addr;
    bit         we;
    logic [7:0] dout;
    bit         q;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [7:0] m_r [16];
  logic [7:0] m_mem [256];
  bit         m_halt;
  bit         m_quit;
  logic [7:0] m_haddr;
  logic [7:0] prog [256];

  int         st_count;
  logic [7:0] st_first;
  logic [7:0] st_last;
  logic [7:0] st_last_addr;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_cyc(bit ca, logic [7:0] a, bit we, logic [7:0] d);
    cyc_t c;
    c.chk_addr = ca;
    c.addr     = a;
    c.we       = we;
    c.dout     = d;
    c.q        = m_quit;
    exp_q.push_back(c);
  endfunction

  task automatic model_step();
    logic [7:0] o [16];
    logic [7:0] ins, pc, wr, rn, np, sp;
    logic [3:0] op, n;
    if (m_halt) begin
      push_cyc(1'b1, m_haddr, 1'b0, 8'h00);
      return;
    end
    o   = m_r;
    pc  = o[3];
    ins = m_mem[pc];
    op  = ins[7:4];
    n   = ins[3:0];
    wr  = o[0];
    rn  = o[n];
    np  = pc + 8'd1;
    push_cyc(1'b1, pc, 1'b0, 8'h00);
    push_cyc(1'b0, 8'h00, 1'b0, 8'h00);
    case (op)
      4'h1: m_r[0] = {4'h0, n};
      4'h2: m_r[0] = rn;
      4'h3: begin
        m_r[n] = wr;
        if (n == 4'd3) np = wr;
      end
      4'h4: m_r[0] = wr + rn;
      4'h5: m_r[0] = wr - rn;
      4'h6: m_r[0] = wr & rn;
      4'h7: m_r[0] = wr | rn;
      4'h8: m_r[0] = wr ^ rn;
      4'h9: m_r[0] = ~rn;
      4'hA: m_r[0] = (rn >= 8'd8) ? 8'h00 : 8'((int'(wr) * (1 << rn)) % 256);
      4'hB: m_r[0] = (rn >= 8'd8) ? 8'h00 : 8'(int'(wr) / (1 << rn));
      4'hC: m_r[1][0] = (wr == rn);
      4'hD: m_r[1][0] = (wr < rn);
      4'hE: begin
        push_cyc(1'b1, rn, 1'b1, wr);
        m_mem[rn] = wr;
      end
      4'hF: begin
        push_cyc(1'b1, rn, 1'b0, 8'h00);
        push_cyc(1'b0, 8'h00, 1'b0, 8'h00);
        m_r[0] = m_mem[rn];
      end
      default: begin
        case (n)
          4'h8: if (o[1][0]) np = wr;
          4'hD: m_r[1][0] = ~o[1][0];
          4'hF: begin
            m_haddr = pc;
            m_quit  = 1'b1;
            m_halt  = 1'b1;
            return;
          end
`ifdef ASRM_STACK_EN
          4'h9: begin
            sp     = o[2] - 8'd1;
            m_r[2] = sp;
            push_cyc(1'b1, sp, 1'b0, 8'h00);
            push_cyc(1'b0, 8'h00, 1'b0, 8'h00);
            m_r[0] = m_mem[sp];
          end
          4'hA: begin
            push_cyc(1'b1, o[2], 1'b1, wr);
            m_mem[o[2]] = wr;
            m_r[2] = o[2] + 8'd1;
          end
          4'hB: begin
            push_cyc(1'b1, o[2], 1'b1, np);
            m_mem[o[2]] = np;
            m_r[2] = o[2] + 8'd1;
            np = wr;
          end
          4'hC: begin
            sp     = o[2] - 8'd1;
            m_r[2] = sp;
            push_cyc(1'b1, sp, 1'b0, 8'h00);
            push_cyc(1'b0, 8'h00, 1'b0, 8'h00);
            np = m_mem[sp];
          end
`endif
          default: ;
        endcase
      end
    endcase
    m_r[3] = np;
  endtask

  task automatic check_cycle();
    cyc_t c;
    if (exp_q.size() == 0) model_step();
    c = exp_q.pop_front();
    if (c.chk_addr) chk("addr", addr, c.addr);
    chk("write_en", 8'(write_en), 8'(c.we));
    if (c.we) chk("data_out", data_out, c.dout);
    chk("quit", 8'(quit), 8'(c.q));
    if (write_en === 1'b1) begin
      if (st_count == 0) st_first = data_out;
      st_last      = data_out;
      st_last_addr = addr;
      st_count++;
    end
  endtask

  task automatic run(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      check_cycle();
    end
  endtask

  task automatic start(input bit do_load);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
    m_halt   = 1'b0;
    m_quit   = 1'b0;
    st_count = 0;
    @(negedge clk);
    if (do_load) begin
      ld_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
        ld_addr  = 8'(i);
        ld_data  = prog[i];
        m_mem[i] = prog[i];
        @(negedge clk);
      end
      ld_en = 1'b0;
    end
    @(negedge clk);
    chk("rst_quit", 8'(quit), 8'h00);
    chk("rst_we", 8'(write_en), 8'h00);
    chk("rst_addr", addr, 8'h00);
    reset = 1'b0;
  endtask

  task automatic set_prog(input logic [7:0] p [$]);
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    for (int i = 0; i < p.size(); i++) prog[i] = p[i];
  endtask

  initial begin
    // Arithmetic and store.
    set_prog('{8'h15, 8'h34, 8'h13, 8'h44, 8'h35, 8'hE5, 8'h0F});
    start(1'b1);
    run(22);
    chk("p1_store_count", 8'(st_count), 8'd1);
    chk("p1_store_addr", st_last_addr, 8'h08);
    chk("p1_store_data", st_last, 8'h08);
    chk("p1_quit", 8'(quit), 8'h01);

    // Branch taken.
    set_prog('{8'h12, 8'h34, 8'h12, 8'hC4, 8'h17, 8'h08, 8'h00, 8'h0F});
    start(1'b1);
    run(24);
    chk("br_taken_quit", 8'(quit), 8'h01);

    // Branch not taken: falls through to address 6.
    set_prog('{8'h12, 8'h34, 8'h13, 8'hC4, 8'h17, 8'h08, 8'h00, 8'h0F});
    start(1'b1);
    run(24);
    chk("br_fall_quit", 8'(quit), 8'h01);

    // Wrap: 0xFF + 1 stored to address 15.
    set_prog('{8'h1F, 8'h34, 8'h14, 8'h35, 8'h1F, 8'hA5, 8'h74, 8'h36,
               8'h11, 8'h46, 8'hE4, 8'h0F});
    start(1'b1);
    run(32);
    chk("wrap_store_addr", st_last_addr, 8'h0F);
    chk("wrap_store_data", st_last, 8'h00);

    // Stack round-trip.
    set_prog('{8'h1C, 8'h34, 8'h1D, 8'h35, 8'h16, 8'h0A, 8'h10, 8'h09,
               8'hE4, 8'h22, 8'hE5, 8'h0F});
    start(1'b1);
    run(40);
`ifdef ASRM_STACK_EN
    chk("stack_value", st_first, 8'h06);
`else
    chk("stack_value", st_first, 8'h00);
`endif
    chk("stack_sp", st_last, 8'h00);
    chk("stack_quit", 8'(quit), 8'h01);

    // Asynchronous reset during the second pass's store cycle (cycle 29).
    set_prog('{8'h27, 8'h1E, 8'h38, 8'h27, 8'hE8, 8'h15, 8'h37, 8'h10, 8'h33});
    start(1'b1);
    run(30);
    chk("abort_we_before", 8'(write_en), 8'h01);
    chk("abort_data_before", data_out, 8'h05);
    reset = 1'b1;
    #1;
    chk("abort_we", 8'(write_en), 8'h00);
    chk("abort_addr", addr, 8'h00);
    chk("abort_quit", 8'(quit), 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_write", mem[14], 8'h00);
    m_mem[14] = 8'h00;
    start(1'b0);
    run(12);
    chk("restart_wr_zero", st_first, 8'h00);

    // Randomized programs against the reference model.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
      start(1'b1);
      run(300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
